// File: rtl/inst_fetch_decode.sv
`default_nettype none
// ============================================================================
// inst_fetch_decode : byte FIFO + 1/2-byte instruction assembly, valid/ready out
// Optional feature macro: INST_EXT_IMM_EN (2-byte instructions with immediate)
// Revision: 1.0
// ============================================================================
module inst_fetch_decode #(
    parameter int OPC_W     = 3,
    parameter int OPERAND_W = 4,
    parameter int INSTR_W   = OPC_W + 1 + OPERAND_W,
    parameter int DEPTH     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ena,
    input  logic                   flush,
    input  logic [INSTR_W-1:0]     in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OPC_W-1:0]       out_opcode,
    output logic [OPERAND_W-1:0]   out_operand,
    output logic [INSTR_W-1:0]     out_imm,
    output logic                   out_has_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] C_FULL_LVL = LW'(DEPTH);

    generate
        if (INSTR_W != OPC_W + 1 + OPERAND_W) begin : g_bad_instr_w
            $error("inst_fetch_decode: INSTR_W must equal OPC_W+1+OPERAND_W");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("inst_fetch_decode: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic [LW-1:0]      level_d;

    logic               w_clear;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_slot_free;
    logic [INSTR_W-1:0] w_head;

    logic [OPC_W-1:0]     opc_q, opc_d;
    logic [OPERAND_W-1:0] opr_q, opr_d;
    logic                 out_valid_q, out_valid_d;

    // reset and flush are deliberately indistinguishable in effect
    assign w_clear     = reset || flush;
    assign w_full      = (level_q == C_FULL_LVL);
    assign w_empty     = (level_q == '0);
    assign in_ready    = ena && !w_full && !w_clear;
    assign w_push      = in_valid && in_ready;
    assign w_slot_free = !out_valid_q || out_ready;
    assign w_pop       = ena && !w_empty && w_slot_free && !w_clear;
    assign w_head      = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

`ifdef INST_EXT_IMM_EN
    localparam logic [0:0] S_OP  = 1'b0;
    localparam logic [0:0] S_IMM = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [OPC_W-1:0]     hold_opc_q, hold_opc_d;
    logic [OPERAND_W-1:0] hold_opr_q, hold_opr_d;
    logic [INSTR_W-1:0]   imm_q, imm_d;
    logic                 has_imm_q, has_imm_d;

    always_comb begin
        opc_d       = opc_q;
        opr_d       = opr_q;
        imm_d       = imm_q;
        has_imm_d   = has_imm_q;
        state_d     = state_q;
        hold_opc_d  = hold_opc_q;
        hold_opr_d  = hold_opr_q;
        out_valid_d = out_valid_q && !out_ready;
        if (w_pop) begin
            if (state_q == S_IMM) begin
                opc_d       = hold_opc_q;
                opr_d       = hold_opr_q;
                imm_d       = w_head;
                has_imm_d   = 1'b1;
                out_valid_d = 1'b1;
                state_d     = S_OP;
            end else if (w_head[OPERAND_W]) begin
                // first half only: output register waits for the immediate
                hold_opc_d = w_head[INSTR_W-1 -: OPC_W];
                hold_opr_d = w_head[OPERAND_W-1:0];
                state_d    = S_IMM;
            end else begin
                opc_d       = w_head[INSTR_W-1 -: OPC_W];
                opr_d       = w_head[OPERAND_W-1:0];
                imm_d       = '0;
                has_imm_d   = 1'b0;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_clear) begin
            opc_q       <= '0;
            opr_q       <= '0;
            imm_q       <= '0;
            has_imm_q   <= 1'b0;
            out_valid_q <= 1'b0;
            state_q     <= S_OP;
            hold_opc_q  <= '0;
            hold_opr_q  <= '0;
        end else begin
            opc_q       <= opc_d;
            opr_q       <= opr_d;
            imm_q       <= imm_d;
            has_imm_q   <= has_imm_d;
            out_valid_q <= out_valid_d;
            state_q     <= state_d;
            hold_opc_q  <= hold_opc_d;
            hold_opr_q  <= hold_opr_d;
        end
    end

    assign out_imm     = imm_q;
    assign out_has_imm = has_imm_q;
`else
    // EXT bit has no meaning when every byte is a full instruction
    logic w_unused_ext;
    assign w_unused_ext = w_head[OPERAND_W];

    always_comb begin
        opc_d       = opc_q;
        opr_d       = opr_q;
        out_valid_d = out_valid_q && !out_ready;
        if (w_pop) begin
            opc_d       = w_head[INSTR_W-1 -: OPC_W];
            opr_d       = w_head[OPERAND_W-1:0];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_clear) begin
            opc_q       <= '0;
            opr_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            opc_q       <= opc_d;
            opr_q       <= opr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_imm     = '0;
    assign out_has_imm = 1'b0;
`endif

    assign out_opcode  = opc_q;
    assign out_operand = opr_q;
    assign out_valid   = out_valid_q;
    assign fifo_level  = level_q;

endmodule
`default_nettype wire
